// File: rtl/rst_seq.sv
// Staged reset sequencer: holds NUM_STAGES resets until the PLL lock has been stable,
// then releases them in order (stage 0 first). Re-sequences on lock loss or software request.
module rst_seq #(
  parameter int NUM_STAGES   = 3,
  parameter int LOCK_STABLE  = 8,
  parameter int STAGE_DELAY  = 4,
  parameter int LOCK_TIMEOUT = 1000
) (
  input  logic                  clk,
  input  logic                  s_reset,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_done,
  output logic                  lock_fail
);

  localparam int CNT_MAX = (LOCK_STABLE > STAGE_DELAY) ? LOCK_STABLE : STAGE_DELAY;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TW      = $clog2(LOCK_TIMEOUT + 1);
  localparam int IW      = $clog2(NUM_STAGES + 1);

  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(STAGE_DELAY - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_SAT     = TW'(LOCK_TIMEOUT);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [TW-1:0]           tmo_cnt, tmo_nxt, tmo_inc;
  logic [IW-1:0]           idx, idx_nxt;
  logic [NUM_STAGES-1:0]   rst_out_nxt;
  logic                    seq_done_nxt;
  logic                    lock_fail_nxt;

  assign tmo_inc = (tmo_cnt == TMO_SAT) ? tmo_cnt : tmo_cnt + TW'(1);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt     = state;
    cnt_nxt       = cnt;
    tmo_nxt       = tmo_cnt;
    idx_nxt       = idx;
    rst_out_nxt   = rst_out;
    seq_done_nxt  = seq_done;
    lock_fail_nxt = lock_fail;

    if (state == WAIT_LOCK) begin
      rst_out_nxt  = '1;
      seq_done_nxt = 1'b0;
      if (pll_locked) begin
        state_nxt = STABLE;
        cnt_nxt   = '0;
        tmo_nxt   = '0;
      end else begin
        tmo_nxt = tmo_inc;
        if (tmo_inc >= TMO_LAST) lock_fail_nxt = 1'b1;
      end
    end else if (!pll_locked) begin
      // Lock loss outranks a software request arriving in the same cycle.
      state_nxt    = WAIT_LOCK;
      rst_out_nxt  = '1;
      seq_done_nxt = 1'b0;
      cnt_nxt      = '0;
      idx_nxt      = '0;
      tmo_nxt      = '0;
    end else if (sw_reset_req) begin
      state_nxt    = STABLE;
      rst_out_nxt  = '1;
      seq_done_nxt = 1'b0;
      cnt_nxt      = '0;
      idx_nxt      = '0;
    end else begin
      case (state)
        STABLE: begin
          if (cnt == STABLE_LAST) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt == DELAY_LAST) begin
            cnt_nxt = '0;
            // Shifting zeros in from the LSB clears stages strictly in index order.
            rst_out_nxt = rst_out << 1;
            idx_nxt     = idx + IW'(1);
            if (idx == IDX_LAST) begin
              state_nxt    = DONE;
              seq_done_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          rst_out_nxt  = '0;
          seq_done_nxt = 1'b1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (s_reset) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      tmo_cnt   <= '0;
      idx       <= '0;
      rst_out   <= '1;
      seq_done  <= 1'b0;
      lock_fail <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tmo_cnt   <= tmo_nxt;
      idx       <= idx_nxt;
      rst_out   <= rst_out_nxt;
      seq_done  <= seq_done_nxt;
      lock_fail <= lock_fail_nxt;
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq at default parameters: release timing, lock loss,
// software re-sequence, priority and lock timeout.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       s_reset;
  logic       pll_locked;
  logic       sw_reset_req;
  logic [2:0] rst_out;
  logic       seq_done;
  logic       lock_fail;

  int n_cmp = 0;
  int n_err = 0;

  rst_seq #(
    .NUM_STAGES  (3),
    .LOCK_STABLE (8),
    .STAGE_DELAY (4),
    .LOCK_TIMEOUT(1000)
  ) dut (
    .clk         (clk),
    .s_reset     (s_reset),
    .pll_locked  (pll_locked),
    .sw_reset_req(sw_reset_req),
    .rst_out     (rst_out),
    .seq_done    (seq_done),
    .lock_fail   (lock_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One active edge, then settle before inputs change or outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call right after edge E0; checks the 20 following edges against the release schedule.
  task automatic release_check(input string tag);
    logic [2:0] exp_rst;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_rst = (k < 12) ? 3'b111 : (k < 16) ? 3'b110 : (k < 20) ? 3'b100 : 3'b000;
      check($sformatf("%s_rst_k%0d", tag, k), 32'(rst_out), 32'(exp_rst));
      check($sformatf("%s_done_k%0d", tag, k), 32'(seq_done), (k >= 20) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    s_reset      = 1'b1;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;

    // 1: reset values
    repeat (3) tick();
    check("rst_rst_out", 32'(rst_out), 32'h7);
    check("rst_seq_done", 32'(seq_done), 32'd0);
    check("rst_lock_fail", 32'(lock_fail), 32'd0);
    s_reset = 1'b0;
    tick();
    check("wait_rst_out", 32'(rst_out), 32'h7);

    // 2: normal lock and release
    pll_locked = 1'b1;
    tick();
    check("e0_rst_out", 32'(rst_out), 32'h7);
    release_check("s2");
    repeat (3) tick();
    check("done_hold_rst", 32'(rst_out), 32'h0);
    check("done_hold_flag", 32'(seq_done), 32'd1);

    // 3: lock glitch at E0+14, then re-lock restarts the schedule
    pll_locked = 1'b0;
    tick();
    check("loss_done_rst", 32'(rst_out), 32'h7);
    check("loss_done_flag", 32'(seq_done), 32'd0);
    pll_locked = 1'b1;
    tick();
    for (int k = 1; k <= 13; k++) tick();
    check("s3_k13_rst", 32'(rst_out), 32'h6);
    pll_locked = 1'b0;
    tick();
    check("s3_loss_rst", 32'(rst_out), 32'h7);
    check("s3_loss_done", 32'(seq_done), 32'd0);
    pll_locked = 1'b1;
    tick();
    check("s3_e0_rst", 32'(rst_out), 32'h7);
    release_check("s3");

    // 5: software request in DONE re-runs the full window
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    check("sw_rst", 32'(rst_out), 32'h7);
    check("sw_done", 32'(seq_done), 32'd0);
    release_check("s5");

    // 6a: sw request with lock loss -> WAIT_LOCK, so release is one cycle later than a sw restart
    sw_reset_req = 1'b1;
    pll_locked   = 1'b0;
    tick();
    sw_reset_req = 1'b0;
    check("prio_rst", 32'(rst_out), 32'h7);
    check("prio_done", 32'(seq_done), 32'd0);
    pll_locked = 1'b1;
    tick();
    release_check("s6a");

    // 6b: s_reset mid-RELEASE
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    repeat (13) tick();
    check("s6b_mid_rst", 32'(rst_out), 32'h6);
    s_reset = 1'b1;
    tick();
    check("s6b_rst", 32'(rst_out), 32'h7);
    check("s6b_done", 32'(seq_done), 32'd0);
    check("s6b_fail", 32'(lock_fail), 32'd0);
    s_reset    = 1'b0;
    pll_locked = 1'b0;

    // 4: lock timeout sets lock_fail on edge 999 after reset, and it sticks
    repeat (998) tick();
    check("tmo_998", 32'(lock_fail), 32'd0);
    check("tmo_998_rst", 32'(rst_out), 32'h7);
    tick();
    check("tmo_999", 32'(lock_fail), 32'd1);
    repeat (5) tick();
    check("tmo_sticky", 32'(lock_fail), 32'd1);
    pll_locked = 1'b1;
    tick();
    release_check("s4");
    check("tmo_after_done", 32'(lock_fail), 32'd1);
    s_reset = 1'b1;
    tick();
    check("tmo_cleared", 32'(lock_fail), 32'd0);
    check("tmo_cleared_rst", 32'(rst_out), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
